// File: rtl/debug_observe_reader.sv
// debug_observe_reader: samples the *_debug_ shadow nets, either immediately
// or on a masked value match. The frozen snapshot is then streamed to the
// debug host LSB-first over a 1-bit valid/ready serial port.
module debug_observe_reader #(
    parameter int unsigned NUM_NETS = 8,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_NETS-1:0] obs_nets,
    input  logic                arm,
    input  logic                trig_mode,
    input  logic [NUM_NETS-1:0] match_mask,
    input  logic [NUM_NETS-1:0] match_value,
    input  logic                ser_ready,
    output logic                ser_valid,
    output logic                ser_data,
    output logic                ser_last,
    output logic                busy,
    output logic                timed_out,
    output logic                arm_dropped
);

    localparam int unsigned IW = (NUM_NETS > 1) ? $clog2(NUM_NETS) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value on the last ARMED cycle before expiry.
    localparam logic [TW-1:0] TLIM = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NETS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHIFT
    } state_t;

    state_t              state;
    logic [NUM_NETS-1:0] snap;
    logic [NUM_NETS-1:0] mask_r;
    logic [NUM_NETS-1:0] value_r;
    logic [IW-1:0]       idx;
    logic [TW-1:0]       tcnt;

    logic                match;
    logic [IW-1:0]       idx_nx;

    assign match  = ((obs_nets ^ value_r) & mask_r) == '0;
    assign idx_nx = idx + 1'b1;
    assign busy   = (state != IDLE);

    // Control FSM: capture, match/timeout tracking and serial output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            snap        <= '0;
            mask_r      <= '0;
            value_r     <= '0;
            idx         <= '0;
            tcnt        <= '0;
            ser_valid   <= 1'b0;
            ser_data    <= 1'b0;
            ser_last    <= 1'b0;
            timed_out   <= 1'b0;
            arm_dropped <= 1'b0;
        end else begin
            if (arm && state != IDLE) begin
                arm_dropped <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (arm) begin
                        arm_dropped <= 1'b0;
                        timed_out   <= 1'b0;
                        if (!trig_mode) begin
                            snap      <= obs_nets;
                            idx       <= '0;
                            ser_valid <= 1'b1;
                            ser_data  <= obs_nets[0];
                            ser_last  <= (NUM_NETS == 1);
                            state     <= SHIFT;
                        end else begin
                            mask_r  <= match_mask;
                            value_r <= match_value;
                            tcnt    <= '0;
                            state   <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    // A match wins over expiry on the same cycle.
                    if (match) begin
                        snap      <= obs_nets;
                        idx       <= '0;
                        ser_valid <= 1'b1;
                        ser_data  <= obs_nets[0];
                        ser_last  <= (NUM_NETS == 1);
                        state     <= SHIFT;
                    end else if (TIMEOUT != 0 && tcnt == TLIM) begin
                        timed_out <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (ser_ready) begin
                        if (ser_last) begin
                            ser_valid <= 1'b0;
                            ser_data  <= 1'b0;
                            ser_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            idx      <= idx_nx;
                            ser_data <= snap[idx_nx];
                            ser_last <= (idx_nx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_observe_reader.sv
// Bench for debug_observe_reader: directed stimulus pushes expected serial bits
// into a queue; a negedge monitor pops and compares on every handshake.
module tb_debug_observe_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] obs_nets = '0;
    logic       arm = 1'b0;
    logic       trig_mode = 1'b0;
    logic [7:0] match_mask = '0;
    logic [7:0] match_value = '0;
    logic       ser_ready = 1'b0;
    logic       ser_valid, ser_data, ser_last, busy, timed_out, arm_dropped;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic data;
        logic last;
    } exp_t;
    exp_t exp_q[$];

    debug_observe_reader #(.NUM_NETS(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .obs_nets(obs_nets), .arm(arm),
        .trig_mode(trig_mode), .match_mask(match_mask), .match_value(match_value),
        .ser_ready(ser_ready), .ser_valid(ser_valid), .ser_data(ser_data),
        .ser_last(ser_last), .busy(busy), .timed_out(timed_out),
        .arm_dropped(arm_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = v[i];
            e.last = (i == 7);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_arm(input logic mode, input logic [7:0] m, input logic [7:0] v);
        arm = 1'b1;
        trig_mode = mode;
        match_mask = m;
        match_value = v;
        tick();
        arm = 1'b0;
        match_mask = '0;
        match_value = '0;
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (busy && cycles < budget) begin
            tick();
            cycles++;
        end
        check("idle_reached", busy, 0);
    endtask

    // Monitor: compare every accepted bit and verify hold during stalls.
    initial begin
        logic       stalled;
        logic [1:0] held;
        exp_t       e;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else if (ser_valid) begin
                if (stalled) check("stall_hold", {ser_data, ser_last}, held);
                if (ser_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_bit", ser_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_bit", {ser_data, ser_last}, {e.data, e.last});
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = {ser_data, ser_last};
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        int cyc;
        logic [3:0] pat;

        // Reset state
        tick();
        tick();
        check("reset_outputs", {ser_valid, ser_data, ser_last, busy, timed_out, arm_dropped}, 6'b0);
        rst_n = 1'b1;
        tick();

        // Immediate capture of 0xA5
        ser_ready = 1'b1;
        obs_nets = 8'hA5;
        push_frame(8'hA5, 8);
        do_arm(1'b0, 8'h00, 8'h00);
        check("imm_first_bit", {ser_valid, ser_data, busy}, 3'b111);
        wait_idle(20, cyc);
        check("imm_frame_cycles", cyc, 8);
        check("imm_valid_low", ser_valid, 0);

        // Match trigger: mask F0 value 30
        obs_nets = 8'h00;
        do_arm(1'b1, 8'hF0, 8'h30);
        tick();
        obs_nets = 8'h2F;
        tick();
        check("match_waiting", {busy, ser_valid}, 2'b10);
        obs_nets = 8'h3C;
        push_frame(8'h3C, 8);
        tick();
        check("match_captured", {ser_valid, ser_data}, 2'b10);
        obs_nets = 8'h00;
        wait_idle(20, cyc);

        // Timeout after 4 ARMED cycles
        do_arm(1'b1, 8'hFF, 8'h55);
        tick();
        tick();
        tick();
        check("timeout_still_armed", {busy, timed_out}, 2'b10);
        tick();
        check("timeout_expired", {busy, timed_out, ser_valid}, 3'b010);
        tick();

        // Match on the expiry cycle wins; arm clears timed_out
        do_arm(1'b1, 8'hFF, 8'h55);
        check("timeout_cleared", timed_out, 0);
        tick();
        tick();
        tick();
        obs_nets = 8'h55;
        push_frame(8'h55, 8);
        tick();
        check("match_at_limit", {ser_valid, timed_out}, 2'b10);
        wait_idle(20, cyc);

        // All-zero mask matches on first ARMED cycle
        obs_nets = 8'h12;
        push_frame(8'h12, 8);
        do_arm(1'b1, 8'h00, 8'hFF);
        check("zero_mask_armed", {busy, ser_valid}, 2'b10);
        tick();
        check("zero_mask_capture", ser_valid, 1);
        wait_idle(20, cyc);

        // Backpressure and freeze
        obs_nets = 8'h81;
        push_frame(8'h81, 8);
        do_arm(1'b0, 8'h00, 8'h00);
        obs_nets = 8'hFF;
        pat = 4'b1001;
        cyc = 0;
        while (busy && cyc < 40) begin
            ser_ready = pat[cyc % 4];
            tick();
            cyc++;
        end
        check("bp_done", busy, 0);
        ser_ready = 1'b1;

        // Overrun: arm during SHIFT is dropped
        obs_nets = 8'h5A;
        push_frame(8'h5A, 8);
        do_arm(1'b0, 8'h00, 8'h00);
        tick();
        obs_nets = 8'hFF;
        do_arm(1'b0, 8'h00, 8'h00);
        check("arm_dropped_set", {arm_dropped, busy}, 2'b11);
        wait_idle(20, cyc);
        check("arm_dropped_sticky", arm_dropped, 1);
        obs_nets = 8'h00;
        push_frame(8'h00, 8);
        do_arm(1'b0, 8'h00, 8'h00);
        check("arm_dropped_clear", arm_dropped, 0);
        wait_idle(20, cyc);

        // Async reset at bit 3
        obs_nets = 8'hC6;
        push_frame(8'hC6, 3);
        do_arm(1'b0, 8'h00, 8'h00);
        tick();
        tick();
        tick();
        check("rst_at_bit3", {ser_valid, ser_data, ser_last}, 3'b100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {ser_valid, ser_data, ser_last, busy, timed_out, arm_dropped}, 6'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("post_reset_quiet", {ser_valid, busy}, 2'b00);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_observe_reader.md
# debug_observe_reader

Read-side counterpart to the debug override muxes inserted into instrumented netlists. Those muxes write injected values onto internal nets through `_mux_sel_*_` / `*_mux_input_` ports. This block reads: it samples a vector of `*_debug_` shadow nets, either immediately or on a masked value match, and streams the captured snapshot out LSB-first over a 1-bit valid/ready serial port to the debug host.

## Interface
- `NUM_NETS`, 8: number of observed shadow nets (1..64).
- `TIMEOUT`, 255: maximum cycles spent in ARMED waiting for a match. 0 means no timeout.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `obs_nets`  in  NUM_NETS  shadow-net values, sampled synchronously.
- `arm`  in  1  single-cycle request to start a capture.
- `trig_mode`  in  1  sampled with `arm`. 0 = capture immediately; 1 = capture on match.
- `match_mask`  in  NUM_NETS  bits that participate in the match. Sampled with `arm`.
- `match_value`  in  NUM_NETS  compare value. Sampled with `arm`.
- `ser_ready`  in  1  host accepts the current serial bit.
- `ser_valid`  out  1  `ser_data` is valid.
- `ser_data`  out  1  current snapshot bit.
- `ser_last`  out  1  asserted with the final bit of a frame.
- `busy`  out  1  state is not IDLE.
- `timed_out`  out  1  sticky: the last armed capture expired. Cleared by the next `arm`.
- `arm_dropped`  out  1  sticky: `arm` arrived while busy. Cleared by `arm` in IDLE.

## Operation
- States: IDLE, ARMED, SHIFT.
- IDLE, `arm`=1, `trig_mode`=0:
  - snapshot `obs_nets` into the capture register on that edge;
  - go to SHIFT.
- IDLE, `arm`=1, `trig_mode`=1:
  - latch mask and value into internal registers;
  - clear the timeout counter and go to ARMED.
- ARMED:
  - Each cycle, test `(obs_nets & mask_r) == (value_r & mask_r)`.
  - On a match, snapshot `obs_nets` on that same edge and go to SHIFT.
  - An all-zero mask matches on the first ARMED cycle.
- ARMED timeout:
  - The counter increments every ARMED cycle without a match.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` with no match, go to IDLE and set `timed_out`. No frame is sent.
  - A match on the same cycle the counter reaches `TIMEOUT` takes precedence: capture, `timed_out` stays 0.
- SHIFT:
  - `ser_valid`=1 and `ser_data`=snapshot[idx], with idx starting at 0.
  - Each cycle with `ser_valid && ser_ready`, idx increments.
  - `ser_last`=1 when idx==NUM_NETS-1.
  - The handshake on the last bit returns the block to IDLE.
- Stalling: `ser_data` and `ser_last` hold stable while `ser_valid && !ser_ready`.
- The snapshot is frozen from capture until the frame completes. Later `obs_nets` changes are ignored.
- `arm` while busy is ignored and sets `arm_dropped`. The current operation is unaffected.
- Index counter width is clog2(NUM_NETS), minimum 1. When NUM_NETS=1, `ser_last` is 1 on the only bit.

## Timing
- Reset (any time, asynchronous):
  - state IDLE;
  - `ser_valid`=0, `ser_data`=0, `ser_last`=0;
  - `busy`=0, `timed_out`=0, `arm_dropped`=0;
  - snapshot, mask, value, index and timeout counter all 0.
- Reset mid-SHIFT or mid-ARMED aborts the operation. No partial-frame completion afterwards.
- Immediate mode: `arm` at edge N. `ser_valid`=1 and bit 0 are visible after edge N and hold through cycle N+1.
- Match mode: match true in the cycle ending at edge M. `ser_valid`=1 after edge M.
- A full frame with `ser_ready` held at 1 occupies exactly NUM_NETS cycles of `ser_valid`. `busy` deasserts after the final handshake edge.
- The earliest new `arm` is accepted on the edge after the block returns to IDLE. Back-to-back frames therefore have a 1-cycle gap.
- `busy`=1 in ARMED and SHIFT, combinationally derived from state. All other outputs are registered.

## Test plan
- Immediate capture:
  - stimulus: NUM_NETS=8, `obs_nets`=0xA5, `arm` with `trig_mode`=0, `ser_ready`=1;
  - response: `ser_data` sequence 1,0,1,0,0,1,0,1 over 8 cycles, `ser_last` only on the 8th bit, then `busy`=0.
- Match trigger:
  - stimulus: `arm` with mask 0xF0, value 0x30; `obs_nets` steps 0x00, 0x2F, 0x3C;
  - response: capture on the 0x3C cycle, frame 0x3C.
- Timeout:
  - stimulus: TIMEOUT=4, mask 0xFF, value 0x55, `obs_nets` held at 0;
  - response: after 4 ARMED cycles the block returns to IDLE, `timed_out`=1, `ser_valid` never asserted.
- Backpressure and freeze:
  - stimulus: frame 0x81; `ser_ready` toggles 1,0,0,1,…; `obs_nets` changes to 0xFF during SHIFT;
  - response: data holds during stalls, frame still 0x81, `ser_last` on the 8th accepted bit.
- Overrun:
  - stimulus: `arm` pulsed while in SHIFT;
  - response: `arm_dropped`=1 and the frame is unaffected. A later `arm` in IDLE clears the flag.
- Async reset:
  - stimulus: `rst_n` low at bit 3 of a frame;
  - response: all outputs 0 immediately, state IDLE. After release, no further bits are emitted until a new `arm`.
